rx_block: RTL and testbench

UART receiver: recovers 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) from a serial line and presents each byte with a one-cycle `done` strobe. It is the receive-side counterpart of the UART transmitter in the same design. It samples on an oversampling enable (`clk_en`) supplied by the shared baud generator. It synchronises the asynchronous line internally and reports stop-bit errors.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 25 ++
 rtl/rx_block.sv | 144 ++++++++++++++
 tb/tb_rx_block.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and frame constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_block.sv
// rtl/rx_block.sv - oversampling 8N1 UART receiver with stop-bit error reporting
module rx_block
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] mdata,
    output logic                 done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Start bit is checked mid-bit; data and stop bits one full period later each.
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [TW-1:0]        tick_cnt;
    logic [TW-1:0]        tick_nxt;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic [DATA_BITS-1:0] mdata_nxt;
    logic                 done_nxt;
    logic                 ferr_nxt;
    logic                 rx_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    // Next-state logic; everything holds unless an oversampling tick arrives.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        mdata_nxt = mdata;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_HALF) begin
                        if (!rx_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch, not a start.
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_nxt  = '0;
                        bit_nxt   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt = '0;
                        if (rx_s) begin
                            mdata_nxt = shreg;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line must return high before a new start is accepted.
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            mdata     <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            mdata     <= mdata_nxt;
            done      <= done_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // Any state other than IDLE means a frame (or break) is in progress.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rx_block.sv
// tb/tb_rx_block.sv - randomized self-checking bench for rx_block
module tb_rx_block;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] mdata;
    logic       done;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int en_div = 4;
    int en_cnt = 0;

    logic [7:0] got_q[$];
    int         fe_seen      = 0;
    int         both_seen    = 0;
    int         mdata_glitch = 0;
    logic [7:0] mdata_prev   = 8'h00;

    rx_block dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .rx_in     (rx_in),
        .mdata     (mdata),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Baud-generator stand-in: one-cycle tick every en_div clocks.
    always @(negedge clk) begin
        if (en_cnt >= en_div - 1) begin
            en_cnt = 0;
            clk_en = 1'b1;
        end else begin
            en_cnt = en_cnt + 1;
            clk_en = 1'b0;
        end
    end

    // Record every received byte and error strobe.
    always @(negedge clk) begin
        if (done === 1'b1) got_q.push_back(mdata);
        if (frame_err === 1'b1) fe_seen = fe_seen + 1;
        if (done === 1'b1 && frame_err === 1'b1) both_seen = both_seen + 1;
        if (mdata !== mdata_prev && done !== 1'b1 && rst !== 1'b1) mdata_glitch = mdata_glitch + 1;
        mdata_prev = mdata;
    end

    // Drive nbits serial bits; p100 is the bit period in hundredths of a clk cycle.
    task automatic drive_bits(input logic [15:0] bits, input int nbits, input int p100);
        int t_prev;
        int t_next;
        t_prev = 0;
        for (int k = 0; k < nbits; k++) begin
            rx_in  = bits[k];
            t_next = ((k + 1) * p100) / 100;
            repeat (t_next - t_prev) @(negedge clk);
            t_prev = t_next;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int p100);
        drive_bits({6'h3f, stop, b, 1'b0}, 10, p100);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (mdata !== 8'h00) begin bad++; $display("FAIL reset_mdata got=%h exp=00", mdata); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        idle(80);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL idle_no_frame got=%0d exp=0", got_q.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_nominal;
        int n0;
        int f0;
        n0 = got_q.size();
        f0 = fe_seen;
        send_frame(8'hA5, 1'b1, 6400);
        idle(64);
        total++; if (got_q.size() != n0 + 1) begin bad++; $display("FAIL nominal_count got=%0d exp=%0d", got_q.size(), n0 + 1); end
        if (got_q.size() > n0) begin
            total++; if (got_q[n0] !== 8'hA5) begin bad++; $display("FAIL nominal_data got=%h exp=a5", got_q[n0]); end
        end
        total++; if (mdata !== 8'hA5) begin bad++; $display("FAIL nominal_mdata got=%h exp=a5", mdata); end
        total++; if (fe_seen != f0) begin bad++; $display("FAIL nominal_ferr got=%0d exp=%0d", fe_seen, f0); end
    endtask

    task automatic test_glitch;
        int n0;
        int f0;
        int seen_busy;
        int waited;
        n0 = got_q.size();
        f0 = fe_seen;
        seen_busy = 0;
        rx_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy = 1;
        end
        rx_in = 1'b1;
        waited = 0;
        while (busy !== 1'b0 && waited < 36) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy = 1;
            waited++;
        end
        total++; if (seen_busy != 1) begin bad++; $display("FAIL glitch_detected got=%0d exp=1", seen_busy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_timeout got=%b exp=0", busy); end
        idle(80);
        total++; if (got_q.size() != n0) begin bad++; $display("FAIL glitch_done got=%0d exp=%0d", got_q.size(), n0); end
        total++; if (fe_seen != f0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=%0d", fe_seen, f0); end
    endtask

    task automatic test_frame_err;
        int n0;
        int f0;
        n0 = got_q.size();
        f0 = fe_seen;
        send_frame(8'h3C, 1'b0, 6400);
        repeat (32) @(negedge clk);
        total++; if (fe_seen != f0 + 1) begin bad++; $display("FAIL ferr_pulse got=%0d exp=%0d", fe_seen, f0 + 1); end
        total++; if (got_q.size() != n0) begin bad++; $display("FAIL ferr_no_done got=%0d exp=%0d", got_q.size(), n0); end
        total++; if (mdata !== 8'hA5) begin bad++; $display("FAIL ferr_mdata_hold got=%h exp=a5", mdata); end
        repeat (160) @(negedge clk);
        total++; if (fe_seen != f0 + 1) begin bad++; $display("FAIL break_no_ferr got=%0d exp=%0d", fe_seen, f0 + 1); end
        total++; if (got_q.size() != n0) begin bad++; $display("FAIL break_no_frame got=%0d exp=%0d", got_q.size(), n0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b exp=1", busy); end
        idle(128);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_exit got=%b exp=0", busy); end
        send_frame(8'h81, 1'b1, 6400);
        idle(64);
        total++; if (got_q.size() != n0 + 1) begin bad++; $display("FAIL after_break_count got=%0d exp=%0d", got_q.size(), n0 + 1); end
        total++; if (mdata !== 8'h81) begin bad++; $display("FAIL after_break_mdata got=%h exp=81", mdata); end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = got_q.size();
        send_frame(8'h00, 1'b1, 6400);
        send_frame(8'hFF, 1'b1, 6400);
        idle(64);
        total++; if (got_q.size() != n0 + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), n0 + 2); end
        if (got_q.size() >= n0 + 2) begin
            total++; if (got_q[n0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", got_q[n0]); end
            total++; if (got_q[n0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", got_q[n0+1]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int         n0;
        logic [7:0] b;
        b  = 8'h5A;
        n0 = got_q.size();
        drive_bits({11'h000, b[3:0], 1'b0}, 5, 6400);
        rx_in = b[4];
        repeat (32) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (mdata !== 8'h00) begin bad++; $display("FAIL midrst_mdata got=%h exp=00", mdata); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(64);
        total++; if (got_q.size() != n0) begin bad++; $display("FAIL midrst_partial got=%0d exp=%0d", got_q.size(), n0); end
        send_frame(b, 1'b1, 6400);
        idle(64);
        total++; if (got_q.size() != n0 + 1) begin bad++; $display("FAIL midrst_rx_count got=%0d exp=%0d", got_q.size(), n0 + 1); end
        total++; if (mdata !== 8'h5A) begin bad++; $display("FAIL midrst_rx_mdata got=%h exp=5a", mdata); end
    endtask

    // Random bytes, random stop-bit validity, random skew and gaps at one tick per clk.
    task automatic test_random;
        logic [7:0] exp_q[$];
        int         exp_fe;
        int         n0;
        int         f0;
        logic [7:0] b;
        logic       stop;
        int         p;
        en_div = 1;
        idle(32);
        n0 = got_q.size();
        f0 = fe_seen;
        exp_fe = 0;
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            p    = 1552 + $urandom_range(0, 96);
            send_frame(b, stop, p);
            if (stop) begin
                exp_q.push_back(b);
                idle($urandom_range(0, 20));
            end else begin
                exp_fe++;
                idle($urandom_range(16, 40));
            end
        end
        idle(48);
        total++; if (got_q.size() != n0 + exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - n0, exp_q.size()); end
        total++; if (fe_seen != f0 + exp_fe) begin bad++; $display("FAIL rand_ferr got=%0d exp=%0d", fe_seen - f0, exp_fe); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (n0 + i < got_q.size()) begin
                total++;
                if (got_q[n0+i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_q[n0+i], exp_q[i]); end
            end
        end
    endtask

    // All byte values sent continuously by a transmitter model with alternating +/-3% skew.
    task automatic test_loopback;
        logic [7:0] exp_q[$];
        int         n0;
        int         f0;
        logic [7:0] b;
        en_div = 1;
        idle(32);
        n0 = got_q.size();
        f0 = fe_seen;
        for (int v = 0; v < 256; v++) begin
            b = 8'(v);
            send_frame(b, 1'b1, (v % 2 == 1) ? 1552 : 1648);
            exp_q.push_back(b);
        end
        idle(48);
        total++; if (got_q.size() != n0 + 256) begin bad++; $display("FAIL loop_count got=%0d exp=%0d", got_q.size() - n0, 256); end
        total++; if (fe_seen != f0) begin bad++; $display("FAIL loop_ferr got=%0d exp=%0d", fe_seen, f0); end
        for (int i = 0; i < 256; i++) begin
            if (n0 + i < got_q.size()) begin
                total++;
                if (got_q[n0+i] !== exp_q[i]) begin bad++; $display("FAIL loop_data[%0d] got=%h exp=%h", i, got_q[n0+i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_invariants;
        total++; if (both_seen != 0) begin bad++; $display("FAIL done_and_ferr got=%0d exp=0", both_seen); end
        total++; if (mdata_glitch != 0) begin bad++; $display("FAIL mdata_change_without_done got=%0d exp=0", mdata_glitch); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_loopback();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
